uart_path_cmd_parser: RTL and testbench

Receive-side command decoder for the bot's UART link. It consumes bytes delivered by `uart_rx` (`rx_msg` / `rx_complete`) and parses ASCII path-request frames of the form `P-ss-ee-#`. Each valid frame becomes a start/end node pair plus a one-cycle start pulse for the CPU path planner (`CPU_driver`: `SP`, `EP`, `CPU_start`). It is the inbound counterpart of the status messages sent through `uart_tx`. It sits between `uart_rx` and `CPU_driver` in `Astrotinker_main`.

---
 rtl/astro_uart_pkg.sv | 37 +++
 rtl/uart_path_cmd_parser_if.sv | 23 ++
 rtl/ascii_digit_check.sv | 14 +
 rtl/uart_path_cmd_parser.sv | 215 +++++++++++++++++++++
 tb/tb_uart_path_cmd_parser.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/astro_uart_pkg.sv
// Shared UART-link definitions: ASCII constants, parser/issue state
// encodings and node arithmetic used by the receive and transmit sides.
package astro_uart_pkg;

    localparam int NODE_W = 5;

    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;

    typedef enum logic [3:0] {
        P_IDLE,
        P_DASH1,
        P_SP10,
        P_SP1,
        P_DASH2,
        P_EP10,
        P_EP1,
        P_DASH3,
        P_END
    } p_state_e;

    typedef enum logic {
        I_IDLE,
        I_BUSY
    } i_state_e;

    // Two decimal digits to a 7-bit node value: t*10 + o using shifts.
    function automatic logic [6:0] node_value(input logic [3:0] t, input logic [3:0] o);
        logic [6:0] t7;
        t7 = {3'b000, t};
        return (t7 << 3) + (t7 << 1) + {3'b000, o};
    endfunction

endpackage

// File: rtl/uart_path_cmd_parser_if.sv
// Byte stream in from uart_rx, node request out to the CPU path planner.
interface uart_path_cmd_parser_if;
    import astro_uart_pkg::*;

    logic [7:0]        rx_msg;
    logic              rx_complete;
    logic              cpu_done;
    logic [NODE_W-1:0] SP;
    logic [NODE_W-1:0] EP;
    logic              CPU_start;
    logic              busy;
    logic              frame_err;

    modport master (
        output rx_msg, rx_complete, cpu_done,
        input  SP, EP, CPU_start, busy, frame_err
    );

    modport slave (
        input  rx_msg, rx_complete, cpu_done,
        output SP, EP, CPU_start, busy, frame_err
    );
endinterface

// File: rtl/ascii_digit_check.sv
// Classifies a byte as an ASCII decimal digit and returns its value.
module ascii_digit_check
    import astro_uart_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic [3:0] value
);

    assign is_digit = (ch >= CH_0) && (ch <= CH_9);
    // Only meaningful when is_digit is set.
    assign value    = 4'(ch - CH_0);

endmodule

// File: rtl/uart_path_cmd_parser.sv
// Parses "P-ss-ee-#" frames from the UART byte stream and issues start/end
// node pairs to the path planner, holding one pending request while busy.
module uart_path_cmd_parser
    import astro_uart_pkg::*;
#(
    parameter int NODE_COUNT     = 30,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic                    clk_50M,
    input logic                    reset,
    uart_path_cmd_parser_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    p_state_e          p_state_q, p_state_d;
    logic [3:0]        sp_tens_q, sp_tens_d;
    logic [3:0]        ep_tens_q, ep_tens_d;
    logic [NODE_W-1:0] sp_val_q,  sp_val_d;
    logic [NODE_W-1:0] ep_val_q,  ep_val_d;
    logic [TW-1:0]     timer_q,   timer_d;
    logic              frame_err_q, frame_err_d;

    i_state_e          i_state_q, i_state_d;
    logic [NODE_W-1:0] sp_q, sp_d;
    logic [NODE_W-1:0] ep_q, ep_d;
    logic              start_q, start_d;
    logic              busy_q,  busy_d;
    logic              pend_vld_q, pend_vld_d;
    logic [NODE_W-1:0] pend_sp_q,  pend_sp_d;
    logic [NODE_W-1:0] pend_ep_q,  pend_ep_d;

    logic       is_digit;
    logic [3:0] dig_val;
    logic [6:0] sp_node, ep_node;
    logic       frame_done;
    logic       timeout;

    ascii_digit_check u_digit (
        .ch       (bus.rx_msg),
        .is_digit (is_digit),
        .value    (dig_val)
    );

    assign sp_node = node_value(sp_tens_q, dig_val);
    assign ep_node = node_value(ep_tens_q, dig_val);

    // A byte arriving in the expiring cycle wins over the timeout.
    assign timeout = (p_state_q != P_IDLE) && !bus.rx_complete &&
                     (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Parser next state, digit capture, range check and inter-byte timer.
    always_comb begin
        logic bad;
        bad         = 1'b0;
        p_state_d   = p_state_q;
        sp_tens_d   = sp_tens_q;
        ep_tens_d   = ep_tens_q;
        sp_val_d    = sp_val_q;
        ep_val_d    = ep_val_q;
        frame_err_d = 1'b0;
        frame_done  = 1'b0;

        if (bus.rx_complete || p_state_q == P_IDLE) timer_d = '0;
        else                                        timer_d = timer_q + TW'(1);

        if (bus.rx_complete) begin
            case (p_state_q)
                P_IDLE:  if (bus.rx_msg == CH_P) p_state_d = P_DASH1;
                P_DASH1: if (bus.rx_msg == CH_DASH) p_state_d = P_SP10; else bad = 1'b1;
                P_SP10: begin
                    if (is_digit) begin
                        sp_tens_d = dig_val;
                        p_state_d = P_SP1;
                    end else bad = 1'b1;
                end
                P_SP1: begin
                    if (!is_digit) bad = 1'b1;
                    else if (sp_node >= 7'(NODE_COUNT)) begin
                        frame_err_d = 1'b1;
                        p_state_d   = P_IDLE;
                    end else begin
                        sp_val_d  = NODE_W'(sp_node);
                        p_state_d = P_DASH2;
                    end
                end
                P_DASH2: if (bus.rx_msg == CH_DASH) p_state_d = P_EP10; else bad = 1'b1;
                P_EP10: begin
                    if (is_digit) begin
                        ep_tens_d = dig_val;
                        p_state_d = P_EP1;
                    end else bad = 1'b1;
                end
                P_EP1: begin
                    if (!is_digit) bad = 1'b1;
                    else if (ep_node >= 7'(NODE_COUNT)) begin
                        frame_err_d = 1'b1;
                        p_state_d   = P_IDLE;
                    end else begin
                        ep_val_d  = NODE_W'(ep_node);
                        p_state_d = P_DASH3;
                    end
                end
                P_DASH3: if (bus.rx_msg == CH_DASH) p_state_d = P_END; else bad = 1'b1;
                P_END: begin
                    if (bus.rx_msg == CH_HASH) begin
                        frame_done = 1'b1;
                        p_state_d  = P_IDLE;
                    end else bad = 1'b1;
                end
                default: p_state_d = P_IDLE;
            endcase
        end else if (timeout) begin
            frame_err_d = 1'b1;
            p_state_d   = P_IDLE;
        end

        // An unexpected 'P' aborts the current frame and starts a new one.
        if (bad) begin
            frame_err_d = 1'b1;
            p_state_d   = (bus.rx_msg == CH_P) ? P_DASH1 : P_IDLE;
        end
    end

    // Issue FSM: launch immediately when idle, otherwise park in the pending slot.
    always_comb begin
        i_state_d  = i_state_q;
        sp_d       = sp_q;
        ep_d       = ep_q;
        start_d    = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_sp_d  = pend_sp_q;
        pend_ep_d  = pend_ep_q;

        case (i_state_q)
            I_IDLE: begin
                if (frame_done) begin
                    sp_d      = sp_val_q;
                    ep_d      = ep_val_q;
                    start_d   = 1'b1;
                    i_state_d = I_BUSY;
                end
            end
            I_BUSY: begin
                if (bus.cpu_done) begin
                    // A frame finishing this cycle is newer than anything pending.
                    if (frame_done) begin
                        sp_d       = sp_val_q;
                        ep_d       = ep_val_q;
                        start_d    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else if (pend_vld_q) begin
                        sp_d       = pend_sp_q;
                        ep_d       = pend_ep_q;
                        start_d    = 1'b1;
                        pend_vld_d = 1'b0;
                    end else begin
                        i_state_d  = I_IDLE;
                    end
                end else if (frame_done) begin
                    pend_vld_d = 1'b1;
                    pend_sp_d  = sp_val_q;
                    pend_ep_d  = ep_val_q;
                end
            end
            default: i_state_d = I_IDLE;
        endcase

        busy_d = (i_state_d == I_BUSY);
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            p_state_q   <= P_IDLE;
            sp_tens_q   <= '0;
            ep_tens_q   <= '0;
            sp_val_q    <= '0;
            ep_val_q    <= '0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
            i_state_q   <= I_IDLE;
            sp_q        <= '0;
            ep_q        <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_sp_q   <= '0;
            pend_ep_q   <= '0;
        end else begin
            p_state_q   <= p_state_d;
            sp_tens_q   <= sp_tens_d;
            ep_tens_q   <= ep_tens_d;
            sp_val_q    <= sp_val_d;
            ep_val_q    <= ep_val_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            i_state_q   <= i_state_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            pend_vld_q  <= pend_vld_d;
            pend_sp_q   <= pend_sp_d;
            pend_ep_q   <= pend_ep_d;
        end
    end

    assign bus.SP        = sp_q;
    assign bus.EP        = ep_q;
    assign bus.CPU_start = start_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_path_cmd_parser.sv
// Directed frames with a scoreboard of expected issue/error events; a
// negedge monitor pops and compares whenever CPU_start or frame_err fires.
module tb_uart_path_cmd_parser;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_path_cmd_parser_if dif ();

    uart_path_cmd_parser #(
        .NODE_COUNT     (30),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_50M (clk),
        .reset   (reset),
        .bus     (dif.slave)
    );

    typedef struct {
        bit         is_issue;
        logic [4:0] sp;
        logic [4:0] ep;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset && (dif.frame_err || dif.CPU_start)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got start=%0b err=%0b SP=%0d EP=%0d, expected no event",
                         dif.CPU_start, dif.frame_err, dif.SP, dif.EP);
            end else begin
                bit bad;
                e = q.pop_front();
                if (e.is_issue)
                    bad = !dif.CPU_start || dif.frame_err || dif.SP != e.sp || dif.EP != e.ep;
                else
                    bad = !dif.frame_err || dif.CPU_start;
                if (bad) begin
                    n_err++;
                    $display("FAIL event_%s: got start=%0b err=%0b SP=%0d EP=%0d, expected issue=%0b SP=%0d EP=%0d",
                             e.is_issue ? "issue" : "error", dif.CPU_start, dif.frame_err,
                             dif.SP, dif.EP, e.is_issue, e.sp, e.ep);
                end
            end
        end
    end

    task automatic push_issue(input logic [4:0] sp, input logic [4:0] ep);
        exp_t x;
        x.is_issue = 1'b1; x.sp = sp; x.ep = ep;
        q.push_back(x);
    endtask

    task automatic push_err();
        exp_t x;
        x.is_issue = 1'b0; x.sp = '0; x.ep = '0;
        q.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        dif.rx_msg      = b;
        dif.rx_complete = 1'b1;
        @(posedge clk); #1;
        dif.rx_complete = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_done();
        dif.cpu_done = 1'b1;
        @(posedge clk); #1;
        dif.cpu_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Outputs packed as {SP,EP,CPU_start,busy,frame_err}.
    function automatic logic [31:0] outs();
        return {19'd0, dif.SP, dif.EP, dif.CPU_start, dif.busy, dif.frame_err};
    endfunction

    initial begin
        reset = 1'b1;
        dif.rx_msg = 8'h00; dif.rx_complete = 1'b0; dif.cpu_done = 1'b0;
        idle(3);
        check("reset_outputs", outs(), 32'd0);
        reset = 1'b0;
        idle(2);

        // Basic issue with one-cycle latency after '#'.
        push_issue(5'd3, 5'd17);
        send_str("P-03-17-#");
        check("issue_latency", {29'd0, dif.CPU_start, dif.SP == 5'd3, dif.EP == 5'd17}, 32'd7);
        check("busy_after_issue", dif.busy, 1);
        idle(2);
        check("start_one_cycle", dif.CPU_start, 0);
        pulse_done();
        check("busy_after_done", dif.busy, 0);

        // cpu_done while idle does nothing.
        pulse_done();
        idle(1);
        check("done_when_idle", dif.busy, 0);

        // Range errors, including the exact NODE_COUNT boundary, then a legal maximum.
        push_err();
        send_str("P-31-02-#");
        push_err();
        send_str("P-00-30-#");
        push_issue(5'd0, 5'd29);
        send_str("P-00-29-#");
        pulse_done();
        push_issue(5'd29, 5'd29);
        send_str("P-29-29-#");
        pulse_done();
        idle(1);
        check("busy_after_range", dif.busy, 0);

        // Restart on a stray 'P'.
        push_err();
        push_issue(5'd5, 5'd12);
        send_str("P-0P-05-12-#");
        pulse_done();

        // Pending slot: newest frame wins.
        push_issue(5'd1, 5'd2);
        send_str("P-01-02-#");
        send_str("P-04-05-#");
        send_str("P-06-07-#");
        idle(2);
        push_issue(5'd6, 5'd7);
        pulse_done();
        check("pending_issue", {30'd0, dif.CPU_start, dif.busy}, 32'd3);
        check("pending_nodes", {22'd0, dif.SP, dif.EP}, {22'd0, 5'd6, 5'd7});
        pulse_done();
        idle(1);
        check("pending_cleared", dif.busy, 0);

        // Timeout mid-frame; the tail is then ignored.
        push_err();
        send_str("P-1");
        idle(90);
        check("no_early_timeout", q.size(), 1);
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
        check("timeout_err", q.size(), 0);
        send_str("-2-03-#");
        idle(3);
        check("after_timeout_idle", dif.busy, 0);

        // Build up state, then reset mid-frame: outputs cleared, no error.
        push_issue(5'd8, 5'd9);
        send_str("P-08-09-#");
        send_str("P-12-");
        reset = 1'b1;
        idle(2);
        check("reset_midframe", outs(), 32'd0);
        reset = 1'b0;
        send_str("34-#");
        idle(2);
        check("reset_discard", outs(), 32'd0);

        // Collision: '#' and cpu_done in the same cycle while busy.
        push_issue(5'd8, 5'd9);
        send_str("P-08-09-#");
        push_issue(5'd10, 5'd11);
        send_str("P-10-11-");
        dif.rx_msg = 8'h23; dif.rx_complete = 1'b1; dif.cpu_done = 1'b1;
        @(posedge clk); #1;
        dif.rx_complete = 1'b0; dif.cpu_done = 1'b0;
        check("collision_issue", {30'd0, dif.CPU_start, dif.busy}, 32'd3);
        idle(1);
        check("collision_busy_held", dif.busy, 1);
        pulse_done();
        check("collision_release", dif.busy, 0);

        idle(5);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
